// File: rtl/micro_sequencer.sv
// Next-microaddress sequencer: JAM branching, Z/N flag register, memory stall and timeout trap.
// Optional breakpoint/halt support is compiled in with MICRO_SEQ_BREAKPOINT_EN.
module micro_sequencer #(
  parameter int         TIMEOUT    = 15,
  parameter logic [8:0] TRAP_ADDR  = 9'h1F0,
  parameter logic [8:0] RESET_ADDR = 9'h000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Addr,
  input  logic [1:0] JAM,
  input  logic [1:0] M,
  input  logic       set_F,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic [7:0] ir_opcode,
  input  logic       mem_ready,
  output logic [7:0] MPC,
  output logic       J_OUT,
  output logic       flag_z,
  output logic       flag_n,
  output logic       stall,
  output logic       mem_timeout
`ifdef MICRO_SEQ_BREAKPOINT_EN
  ,
  input  logic [8:0] bp_addr,
  input  logic       bp_valid,
  input  logic       bp_resume,
  output logic       halted
`endif
);

  localparam logic [7:0] TRAP_CNT = 8'(TIMEOUT - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [8:0] addr_p1;
  logic       flag_z_p1;
  logic       flag_n_p1;
  logic       timeout_p1;
  logic [7:0] stall_cnt;
  logic       halt_freeze;
  logic       mem_req;
  logic       trap_now;
  logic       mem_stall;
  logic       ez;
  logic       en;
  logic [8:0] next_addr;

`ifdef MICRO_SEQ_BREAKPOINT_EN
  logic halted_q;
  // bp_hold suppresses re-breaking until the sequencer loads some other address
  logic bp_hold;
  assign halt_freeze = halted_q;
  assign halted      = halted_q;
`else
  assign halt_freeze = 1'b0;
`endif

  assign mem_req   = |M;
  assign trap_now  = mem_req && !mem_ready && (stall_cnt == TRAP_CNT) && !halt_freeze;
  assign mem_stall = mem_req && !mem_ready && !trap_now;
  assign stall     = mem_stall || halt_freeze;

  assign ez = set_F ? alu_z : flag_z_p1;
  assign en = set_F ? alu_n : flag_n_p1;

  always_comb begin
    next_addr = {1'b0, Addr};
    case (JAM)
      2'b00: next_addr = {1'b0, Addr};
      2'b01: next_addr = {1'b0, ir_opcode};
      2'b10: next_addr = {ez, Addr};
      2'b11: next_addr = {en, Addr};
      default: next_addr = {1'b0, Addr};
    endcase
  end

  // p1: registered control-store address, flags, stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_p1    <= RESET_ADDR;
      flag_z_p1  <= 1'b0;
      flag_n_p1  <= 1'b0;
      timeout_p1 <= 1'b0;
      stall_cnt  <= 8'd0;
    end else if (halt_freeze) begin
      addr_p1 <= addr_p1;
    end else if (trap_now) begin
      addr_p1    <= TRAP_ADDR;
      timeout_p1 <= 1'b1;
      stall_cnt  <= 8'd0;
    end else if (mem_stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else begin
      addr_p1   <= next_addr;
      stall_cnt <= 8'd0;
      if (set_F) begin
        flag_z_p1 <= alu_z;
        flag_n_p1 <= alu_n;
      end
    end
  end

`ifdef MICRO_SEQ_BREAKPOINT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q <= 1'b0;
      bp_hold  <= 1'b0;
    end else if (halted_q) begin
      if (bp_resume) halted_q <= 1'b0;
    end else if (!trap_now && !mem_stall) begin
      if (bp_valid && (next_addr == bp_addr) && !bp_hold) begin
        halted_q <= 1'b1;
        bp_hold  <= 1'b1;
      end else if (next_addr != bp_addr) begin
        bp_hold <= 1'b0;
      end
    end
  end
`endif

  assign {J_OUT, MPC} = addr_p1;
  assign flag_z       = flag_z_p1;
  assign flag_n       = flag_n_p1;
  assign mem_timeout  = timeout_p1;

endmodule
